imem_loader: RTL and testbench

Byte-stream program loader that writes the instruction memory feeding the `risc_kgp` core. It receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes each word into the instruction memory write port at consecutive word addresses, holding the core stalled until the image is complete. It is the writer side of the instruction memory, which the core only reads.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for the risc_kgp instruction memory.
// Optional trailing XOR checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    // Lengths above the memory capacity are rejected, so addresses never wrap.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_FINAL = ST_CHECK;
`else
    localparam logic [2:0] ST_FINAL = ST_DONE;
`endif

    logic [2:0]  state;
    logic [15:0] len_q;
    logic [31:0] word_q;
    logic [1:0]  byte_cnt;
    logic        accept;
    logic [15:0] len_full;
    logic        too_long;
    logic        last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign rx_ready   = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                        (state == ST_DATA)   || (state == ST_CHECK);
    assign accept     = rx_valid && rx_ready;
    assign len_full   = {len_q[15:8], rx_data};
    assign too_long   = {17'd0, len_full} > CAPACITY;
    assign last_word  = (words_loaded + 16'd1) == len_q;

    assign imem_we    = (state == ST_WRITE);
    assign imem_addr  = words_loaded[ADDR_WIDTH-1:0];
    assign imem_wdata = word_q;

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values of words_loaded, len_q and the checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            word_q       <= '0;
            byte_cnt     <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state        <= ST_LEN_HI;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_hold     <= 1'b1;
                        words_loaded <= '0;
                        byte_cnt     <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= rx_data;
                        state       <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= rx_data;
                        if (too_long) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= ST_FINAL;
`ifndef IMEM_LOADER_CHECKSUM_EN
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        word_q   <= {word_q[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                    if (last_word) begin
                        state <= ST_FINAL;
`ifndef IMEM_LOADER_CHECKSUM_EN
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        state <= ST_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every accepted byte except the checksum byte itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR))) begin
            csum <= '0;
        end else if (accept && (state != ST_CHECK)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random loads against a byte-level
// reference model, with a queue-based scoreboard checking every memory write.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 64'(imem_addr), 64'(mon_e.addr));
                check("write_data", 64'(imem_wdata), 64'(mon_e.data));
                check("ready_low_in_write", 64'(rx_ready), 64'd0);
            end
        end
    end

    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    endfunction

    // Called and returns at a falling edge; the byte is accepted on the rising
    // edge following a falling edge where rx_ready is seen high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (rx_ready) ok = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: rx_ready never high for byte 0x%0h", b);
        end
    endtask

    task automatic wait_end();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done || error) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL end_timeout: done=%0b error=%0b required one of them high", done, error);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference model: length prefix, big-endian words at addresses 0..N-1,
    // optional XOR checksum over every byte that precedes it.
    task automatic run_load(input logic [15:0] n, input int gap, input bit bad_cs,
                            input bit use_fixed, input logic [31:0] fixed_word);
        logic [7:0]  cs;
        logic [31:0] w;
        bit          ok;
        bit          too_long;
        $display("info: load n=%0d gap=%0d bad_cs=%0d", n, gap, bad_cs);
        pulse_start();
        check("start_hold", 64'(cpu_hold), 64'd1);
        check("start_done_clr", 64'(done), 64'd0);
        check("start_error_clr", 64'(error), 64'd0);
        check("start_words_clr", 64'(words_loaded), 64'd0);
        check("ready_len_hi", 64'(rx_ready), 64'd1);
        cs = n[15:8] ^ n[7:0];
        send_byte(n[15:8], pick_gap(gap));
        send_byte(n[7:0], pick_gap(gap));
        too_long = 32'(n) > (32'd1 << AW);
        if (!too_long) begin
            for (int i = 0; i < int'(n); i++) begin
                w = (use_fixed && i == 0) ? fixed_word : $urandom;
                exp_q.push_back('{addr: AW'(i), data: w});
                for (int b = 3; b >= 0; b--) begin
                    send_byte(w[b*8 +: 8], pick_gap(gap));
                    cs ^= w[b*8 +: 8];
                end
            end
        end
        ok = !too_long;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!too_long) begin
            send_byte(bad_cs ? (cs ^ 8'h01) : cs, pick_gap(gap));
            ok = !bad_cs;
        end
`endif
        wait_end();
        check("end_done", 64'(done), 64'(ok));
        check("end_error", 64'(error), 64'(!ok));
        check("end_hold", 64'(cpu_hold), 64'(!ok));
        check("end_words", 64'(words_loaded), too_long ? 64'd0 : 64'(n));
        check("writes_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clk);

        run_load(16'd1, 0, 1'b0, 1'b1, 32'hDEADBEEF);
        run_load(16'd3, 2, 1'b0, 1'b0, 32'h0);
        run_load(16'd0, 0, 1'b0, 1'b0, 32'h0);
        run_load(16'h0401, 0, 1'b0, 1'b0, 32'h0);
        run_load(16'd1, 0, 1'b1, 1'b1, 32'h01020304);
        run_load(16'h0400, 0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            run_load(16'($urandom_range(1, 8)), -1, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
        end

        // Abort a 4-word load after two words have been written.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            exp_q.push_back('{addr: AW'(i), data: w});
            for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], 1);
        end
        @(negedge clk);
        check("abort_words_before", 64'(words_loaded), 64'd2);
        check("abort_hold_before", 64'(cpu_hold), 64'd1);
        #2 reset = 1'b0;
        #1 check_reset_values("abort");
        check("abort_writes_pending", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_load(16'd2, -1, 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
